// File: rtl/lp_power_sequencer.sv
// Power sequencer for four switchable domains: runs isolate/save/switch-off and
// switch-on/restore/de-isolate sequences one request at a time. Optional LP_PWR_ACK_EN adds rail-status gating of the waits.
module lp_power_sequencer #(
  parameter int unsigned PWR_OFF_WAIT = 2,
  parameter int unsigned PWR_ON_WAIT  = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       upf_clk,
  input  logic       soc_reset,
  input  logic       req_valid,
  input  logic [1:0] req_dom,
  input  logic       req_on,
`ifdef LP_PWR_ACK_EN
  input  logic [3:0] pwr_ack,
`endif
  output logic       req_ready,
  output logic       done,
  output logic [3:0] pwr_sw_en,
  output logic [3:0] iso_en,
  output logic [3:0] ret_save,
  output logic [3:0] ret_restore,
  output logic [3:0] en_dom
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISO,
    S_SAVE,
    S_OFF_WAIT,
    S_ON_WAIT,
    S_RESTORE,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       dom, dom_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       dom_mask, req_mask;
  logic [3:0]       pwr_nx, iso_nx, en_nx, save_nx, restore_nx;
  logic             ready_nx, done_nx;
  logic             wait_expired, off_ack_ok, on_ack_ok;

  assign dom_mask     = 4'b0001 << dom;
  assign req_mask     = 4'b0001 << req_dom;
  // The counter keeps falling past 1 while an ack is outstanding, so "expired" covers 0 too.
  assign wait_expired = (cnt <= CNT_W'(1));

`ifdef LP_PWR_ACK_EN
  assign off_ack_ok = ~pwr_ack[dom];
  assign on_ack_ok  =  pwr_ack[dom];
`else
  assign off_ack_ok = 1'b1;
  assign on_ack_ok  = 1'b1;
`endif

  always_ff @(posedge upf_clk) begin
    if (soc_reset) begin
      state       <= S_IDLE;
      dom         <= '0;
      cnt         <= '0;
      req_ready   <= 1'b1;
      done        <= 1'b0;
      pwr_sw_en   <= '1;
      en_dom      <= '1;
      iso_en      <= '0;
      ret_save    <= '0;
      ret_restore <= '0;
    end else begin
      state       <= state_nx;
      dom         <= dom_nx;
      cnt         <= cnt_nx;
      req_ready   <= ready_nx;
      done        <= done_nx;
      pwr_sw_en   <= pwr_nx;
      en_dom      <= en_nx;
      iso_en      <= iso_nx;
      ret_save    <= save_nx;
      ret_restore <= restore_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    dom_nx     = dom;
    cnt_nx     = cnt;
    pwr_nx     = pwr_sw_en;
    iso_nx     = iso_en;
    en_nx      = en_dom;
    save_nx    = '0;
    restore_nx = '0;
    ready_nx   = 1'b0;
    done_nx    = 1'b0;

    unique case (state)
      S_IDLE: begin
        ready_nx = 1'b1;
        if (req_valid && req_ready) begin
          dom_nx   = req_dom;
          ready_nx = 1'b0;
          if (req_on == en_dom[req_dom]) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else if (req_on) begin
            state_nx = S_ON_WAIT;
            pwr_nx   = pwr_sw_en | req_mask;
            cnt_nx   = CNT_W'(PWR_ON_WAIT);
          end else begin
            state_nx = S_ISO;
            iso_nx   = iso_en | req_mask;
            en_nx    = en_dom & ~req_mask;
          end
        end
      end
      S_ISO: begin
        state_nx = S_SAVE;
        save_nx  = dom_mask;
      end
      S_SAVE: begin
        state_nx = S_OFF_WAIT;
        pwr_nx   = pwr_sw_en & ~dom_mask;
        cnt_nx   = CNT_W'(PWR_OFF_WAIT);
      end
      S_OFF_WAIT: begin
        if (wait_expired && off_ack_ok) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
          cnt_nx   = '0;
        end else if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_ON_WAIT: begin
        if (wait_expired && on_ack_ok) begin
          state_nx   = S_RESTORE;
          restore_nx = dom_mask;
          cnt_nx     = '0;
        end else if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_RESTORE: begin
        state_nx = S_DONE;
        iso_nx   = iso_en & ~dom_mask;
        en_nx    = en_dom | dom_mask;
        done_nx  = 1'b1;
      end
      S_DONE: begin
        state_nx = S_IDLE;
        ready_nx = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_lp_power_sequencer.sv
// Bench for lp_power_sequencer: per-request timelines are derived from the
// sequence rules and compared every cycle, with randomized busy-time noise and aborts.
module tb_lp_power_sequencer;

  localparam int unsigned N_OFF = 2;
  localparam int unsigned N_ON  = 4;

  logic       clk = 1'b0;
  logic       soc_reset;
  logic       req_valid;
  logic [1:0] req_dom;
  logic       req_on;
  logic       req_ready;
  logic       done;
  logic [3:0] pwr_sw_en, iso_en, ret_save, ret_restore, en_dom;
`ifdef LP_PWR_ACK_EN
  logic [3:0] pwr_ack;
  assign pwr_ack = pwr_sw_en;
`endif

  always #5 clk = ~clk;

  lp_power_sequencer #(
    .PWR_OFF_WAIT(N_OFF),
    .PWR_ON_WAIT (N_ON),
    .CNT_W       (4)
  ) dut (
    .upf_clk    (clk),
    .soc_reset  (soc_reset),
    .req_valid  (req_valid),
    .req_dom    (req_dom),
    .req_on     (req_on),
`ifdef LP_PWR_ACK_EN
    .pwr_ack    (pwr_ack),
`endif
    .req_ready  (req_ready),
    .done       (done),
    .pwr_sw_en  (pwr_sw_en),
    .iso_en     (iso_en),
    .ret_save   (ret_save),
    .ret_restore(ret_restore),
    .en_dom     (en_dom)
  );

  // Reference domain status: which domains are switched on, isolated, enabled.
  logic [3:0] m_pw, m_iso, m_en;
  int unsigned npass = 0;
  int unsigned ntotal = 0;
  int unsigned nfail = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [3:0] sv, input logic [3:0] rs,
                           input logic dn, input logic rd);
    chk("pwr_sw_en", pwr_sw_en, m_pw);
    chk("iso_en", iso_en, m_iso);
    chk("en_dom", en_dom, m_en);
    chk("ret_save", ret_save, sv);
    chk("ret_restore", ret_restore, rs);
    chk("done", {3'b000, done}, {3'b000, dn});
    chk("req_ready", {3'b000, req_ready}, {3'b000, rd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      req_dom = 2'($urandom_range(0, 3));
      req_on  = 1'($urandom_range(0, 1));
      tick();
      check_all('0, '0, 1'b0, 1'b1);
    end
  endtask

  // Issue one request while idle; k counts cycles after the accepting edge.
  // abort_k >= 0 asserts reset right after the check of that cycle.
  task automatic do_req(input logic [1:0] d, input logic on, input int abort_k);
    logic [3:0] b;
    logic [3:0] sv, rs;
    logic       dn, rd;
    int         kind;
    int         last;
    b = 4'b0001 << d;
    if (on == m_en[d]) begin kind = 0; last = 1; end
    else if (on)        begin kind = 2; last = N_ON + 2; end
    else                begin kind = 1; last = N_OFF + 3; end
    req_valid = 1'b1;
    req_dom   = d;
    req_on    = on;
    for (int k = 0; k <= last; k++) begin
      tick();
      sv = '0; rs = '0; dn = 1'b0; rd = 1'b0;
      if (kind == 0) begin
        if (k == 0) dn = 1'b1; else rd = 1'b1;
      end else if (kind == 1) begin
        if (k == 0) begin m_iso = m_iso | b; m_en = m_en & ~b; end
        if (k == 1) sv = b;
        if (k == 2) m_pw = m_pw & ~b;
        if (k == 2 + N_OFF) dn = 1'b1;
        if (k == 3 + N_OFF) rd = 1'b1;
      end else begin
        if (k == 0) m_pw = m_pw | b;
        if (k == N_ON) rs = b;
        if (k == N_ON + 1) begin m_iso = m_iso & ~b; m_en = m_en | b; dn = 1'b1; end
        if (k == N_ON + 2) rd = 1'b1;
      end
      check_all(sv, rs, dn, rd);
      if (k == last) begin
        req_valid = 1'b0;
      end else begin
        // Requester noise while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_dom   = 2'($urandom_range(0, 3));
        req_on    = 1'($urandom_range(0, 1));
      end
      if (k == abort_k && k != last) begin
        soc_reset = 1'b1;
        tick();
        soc_reset = 1'b0;
        req_valid = 1'b0;
        m_pw = '1; m_en = '1; m_iso = '0;
        check_all('0, '0, 1'b0, 1'b1);
        return;
      end
    end
  endtask

  initial begin
    soc_reset = 1'b1;
    req_valid = 1'b0;
    req_dom   = '0;
    req_on    = 1'b0;
    m_pw = '1; m_en = '1; m_iso = '0;
    tick();
    tick();
    check_all('0, '0, 1'b0, 1'b1);
    soc_reset = 1'b0;
    idle(1);

    do_req(2'd2, 1'b0, -1);
    do_req(2'd2, 1'b1, -1);
    do_req(2'd0, 1'b1, -1);
    idle(1);
    do_req(2'd1, 1'b0, 2);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      int ab;
      idle(int'($urandom_range(0, 2)));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ab);
    end
    idle(2);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
